// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath blocks: element width, size limits,
// loader state encoding and the dimension-legality rule.
package matrix_pkg;

  localparam int ELEM_W    = 32;
  localparam int MAX_DIM   = 6;
  localparam int MAX_ELEMS = 36;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A dimension is legal when it is non-zero and no larger than max_dim.
  function automatic logic dims_legal(input logic [2:0] rows,
                                      input logic [2:0] cols,
                                      input int         max_dim);
    return (rows != 3'd0) && (cols != 3'd0) &&
           (int'(rows) <= max_dim) && (int'(cols) <= max_dim);
  endfunction

endpackage

// File: rtl/matrix_loader.sv
// Serial-to-packed matrix writer: takes a row-major valid/ready element stream and
// assembles it into the flat packed matrix consumed by the element-wise units.
module matrix_loader #(
  parameter int MAX_ELEMS = matrix_pkg::MAX_ELEMS,
  parameter int MAX_DIM   = matrix_pkg::MAX_DIM
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [2:0]                                     rows,
  input  logic [2:0]                                     cols,
  input  logic signed [matrix_pkg::ELEM_W-1:0]           in_data,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  output logic signed [MAX_ELEMS*matrix_pkg::ELEM_W-1:0] Mout,
  output logic                                           done,
  output logic                                           err
);
  import matrix_pkg::*;

  state_t                                r_state;
  state_t                                w_next;
  logic [5:0]                            r_total;
  logic [5:0]                            r_idx;
  logic [MAX_ELEMS*ELEM_W-1:0]           r_mout;
  logic                                  r_err;
  logic                                  w_legal;
  logic                                  w_req_ok;
  logic                                  w_req_bad;
  logic                                  w_accept;
  logic                                  w_last;

  assign w_legal   = dims_legal(rows, cols, MAX_DIM);
  assign w_req_ok  = (r_state == ST_IDLE) && start && w_legal;
  assign w_req_bad = (r_state == ST_IDLE) && start && !w_legal;
  assign w_accept  = (r_state == ST_LOAD) && in_valid;
  assign w_last    = (r_idx + 6'd1) == r_total;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req_ok) w_next = ST_LOAD;
      ST_LOAD: if (w_accept && w_last) w_next = ST_DONE;
      ST_DONE: if (!start) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mout  <= '0;
      r_total <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_req_bad;
      if (w_req_ok) begin
        r_total <= 6'(rows) * 6'(cols);
        r_idx   <= '0;
        r_mout  <= '0;
      end else if (w_accept) begin
        r_mout[r_idx*ELEM_W +: ELEM_W] <= in_data;
        // idx parks on the last slot so a full matrix never wraps it
        if (!w_last) r_idx <= r_idx + 6'd1;
      end
    end
  end

  assign in_ready = (r_state == ST_LOAD);
  assign done     = (r_state == ST_DONE);
  assign err      = r_err;
  assign Mout     = r_mout;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed + randomized bench for matrix_loader against an element-list model.
module tb_matrix_loader;
  typedef logic [31:0] word_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [2:0]           rows;
  logic [2:0]           cols;
  logic signed [31:0]   in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [36*32-1:0]     Mout;
  logic                 done;
  logic                 err;

  int    errors = 0;
  int    checks = 0;
  word_t vals[$];
  word_t exp_w[36];

  matrix_loader dut (
    .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .Mout(Mout), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mout(input string tag);
    logic [36*32-1:0] e;
    int b;
    b = 0;
    for (int k = 35; k >= 0; k--) begin
      e[k*32 +: 32] = exp_w[k];
      if (Mout[k*32 +: 32] !== exp_w[k]) b = k;
    end
    checks++;
    assert (Mout === e) else begin
      errors++;
      $error("FAIL %s: word %0d got %0h expected %0h", tag, b, Mout[b*32 +: 32], exp_w[b]);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 36; k++) exp_w[k] = '0;
  endtask

  task automatic rand_vals(input int n);
    vals.delete();
    for (int k = 0; k < n; k++) vals.push_back($urandom);
  endtask

  // Entered and left just after a falling edge. abort_after>=0 stops feeding
  // once that many elements have been accepted and returns still in LOAD.
  task automatic do_load(input int r, input int c, input int stall_pct,
                         input int abort_after, input int hold, input int exp_lat);
    int n, i, cyc;
    bit v, got_done;
    n = r * c; i = 0; cyc = 0; got_done = 0;
    start = 1'b1; rows = 3'(r); cols = 3'(c); in_valid = 1'b0;
    clear_model();
    @(negedge clk); cyc = 1;
    while (1) begin
      if (done) begin got_done = 1; break; end
      if (cyc >= 2000) break;
      if (abort_after >= 0 && i == abort_after) break;
      chk("ready_in_load", word_t'(in_ready), 32'd1);
      v = ($urandom_range(99) >= stall_pct) && (i < n);
      in_valid = v;
      in_data  = v ? vals[i] : $urandom;
      if (v) begin exp_w[i] = vals[i]; i++; end
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    if (abort_after >= 0) return;
    chk("done_seen", word_t'(got_done), 32'd1);
    if (exp_lat >= 0) chk("done_latency", word_t'(cyc), word_t'(exp_lat));
    chk("accepted", word_t'(i), word_t'(n));
    chk("ready_in_done", word_t'(in_ready), 32'd0);
    chk_mout("mout_done");
    repeat (hold) begin
      in_valid = $urandom_range(1); in_data = $urandom;
      rows = 3'($urandom_range(1, 6)); cols = 3'($urandom_range(1, 6));
      @(negedge clk);
      chk("hold_done_ready", word_t'({done, in_ready}), 32'd2);
    end
    if (hold > 0) chk_mout("mout_after_hold");
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("done_clear", word_t'(done), 32'd0);
    chk("idle_ready", word_t'(in_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rows = 3'd0; cols = 3'd0; in_data = '0; in_valid = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_ready", word_t'(in_ready), 32'd0);
    chk("rst_done", word_t'(done), 32'd0);
    chk("rst_err", word_t'(err), 32'd0);
    chk_mout("rst_mout");
    rst = 1'b0;
    @(negedge clk);

    // 2x3, no stalls
    vals = '{32'd1, -32'sd2, 32'd3, -32'sd4, 32'd5, 32'd6};
    do_load(2, 3, 0, -1, 0, 7);

    // illegal dimensions: err every cycle, nothing else moves
    start = 1'b1; rows = 3'd0; cols = 3'd3; in_valid = 1'b1; in_data = $urandom;
    @(negedge clk);
    chk("err_rows0", word_t'(err), 32'd1);
    chk("err_ready", word_t'(in_ready), 32'd0);
    chk("err_done", word_t'(done), 32'd0);
    @(negedge clk);
    chk("err_repeat", word_t'(err), 32'd1);
    rows = 3'd7;
    @(negedge clk);
    chk("err_rows7", word_t'(err), 32'd1);
    chk("err_ready7", word_t'(in_ready), 32'd0);
    chk_mout("err_mout_kept");
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("err_clear", word_t'(err), 32'd0);
    chk("err_idle_ready", word_t'(in_ready), 32'd0);

    // 6x6 with random gaps
    vals.delete();
    for (int k = 0; k < 36; k++) vals.push_back(word_t'(100 + k));
    do_load(6, 6, 40, -1, 0, -1);

    // 3x3 with start held through DONE, then 1x1 re-zeroes the rest
    rand_vals(9);
    do_load(3, 3, 20, -1, 10, -1);
    vals = '{-32'sd7};
    do_load(1, 1, 0, -1, 0, 2);

    // reset after 4 of 9 elements
    rand_vals(9);
    do_load(3, 3, 0, 4, 0, -1);
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = $urandom;
    @(negedge clk);
    clear_model();
    chk("rst_mid_ready", word_t'(in_ready), 32'd0);
    chk("rst_mid_done", word_t'(done), 32'd0);
    chk_mout("rst_mid_mout");
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vals = '{32'd9, 32'd8};
    do_load(1, 2, 0, -1, 0, 3);

    // random shapes
    for (int t = 0; t < 5; t++) begin
      int r, c;
      r = $urandom_range(1, 6); c = $urandom_range(1, 6);
      rand_vals(r * c);
      do_load(r, c, 30, -1, $urandom_range(0, 3), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Serial-to-packed matrix writer: accepts a row-major stream of signed 32-bit elements over a valid/ready handshake and assembles them into the flat packed matrix vector consumed by the matrix arithmetic blocks (`Ain`/`Bin`-style ports). It sits between a host or memory-read stream and the element-wise matrix units. It uses the same `start`/`done` level handshake as those units, so it chains directly ahead of them.

## Interface
- `MAX_ELEMS`, default 36: maximum element count (6x6).
- `MAX_DIM`, default 6: maximum rows or cols.
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  level request; sampled only in IDLE.
- `rows`  in  3  row count, latched on accepted start.
- `cols`  in  3  column count, latched on accepted start.
- `in_data`  in  32 (signed)  stream element, row-major.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept an element.
- `Mout`  out  MAX_ELEMS*32 (signed)  packed matrix; element k at `[k*32 +: 32]`.
- `done`  out  1  matrix complete; held until `start` falls.
- `err`  out  1  one-cycle pulse on an illegal dimension request.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE, `start`=1, dims legal (1..MAX_DIM each):
  - latch `total = rows*cols` (6-bit);
  - set `idx` = 0;
  - zero all of `Mout`;
  - go to LOAD.
- IDLE, `start`=1, dims illegal (either is 0 or >MAX_DIM):
  - `err` = 1 for one cycle;
  - stay in IDLE; `Mout` unchanged.
  - `err` pulses again every cycle that `start` stays high with illegal dims.
- LOAD:
  - `in_ready` = 1.
  - On `in_valid & in_ready`, write `in_data` to `Mout[idx*32 +: 32]` and increment `idx`.
  - If `idx+1 == total`, go to DONE.
  - Elements at index ≥ `total` stay zero.
- DONE:
  - `done` = 1; `in_ready` = 0.
  - Leave for IDLE when `start` = 0; `done` clears on that transition.
- `start` changes and `rows`/`cols` changes outside IDLE are ignored.
- `in_valid` outside LOAD is ignored; no data is consumed.
- Stalls (`in_valid` low in LOAD) hold `idx` and `Mout`; there is no timeout.

## Timing
- Reset values: state IDLE, `in_ready` 0, `done` 0, `err` 0, `Mout` all zero, `idx` 0.
- Reset mid-LOAD or mid-DONE returns to IDLE next edge and zeroes `Mout`; partial data is discarded.
- Start accepted at edge T:
  - LOAD entered and `in_ready` = 1 from T+1.
  - First element can be accepted at T+1.
- Back-to-back elements are accepted one per cycle.
  - With no stalls, last accept is at T+N and `done` = 1 from T+N+1.
- `Mout` is fully stable whenever `done` = 1. `Mout` is not guaranteed complete in IDLE or LOAD.
- `start` held high through DONE:
  - `done` stays 1;
  - no restart until `start` has been low for at least one cycle (observed in DONE → IDLE).
- `start` = 0 in DONE at edge D: IDLE and `done` = 0 at D+1. A new start can be accepted at D+1 at the earliest.
- Single-element matrix (1x1): one accept, then DONE.
- Full matrix (6x6): 36 accepts; `idx` reaches 35 and never wraps.

## Structure
- Shared package `matrix_pkg`, also used by the element-wise units:
  - `ELEM_W` = 32, `MAX_DIM` = 6, `MAX_ELEMS` = 36;
  - dimension-legality function;
  - state encoding constants.
- No sub-module needed; single FSM plus indexed write into the packed register.

## Test plan
- Reset, then 2x3 start, stream 1,-2,3,-4,5,6 with no stalls:
  - `done` rises 7 cycles after the start edge;
  - `Mout` words 0..5 = 1,-2,3,-4,5,6;
  - words 6..35 = 0.
- 6x6 with random `in_valid` gaps, values 100+k:
  - all 36 words correct;
  - `in_ready` never high in DONE;
  - no element lost or duplicated.
- Start with rows=0, then rows=7 (cols=3):
  - `err` pulses;
  - state stays IDLE; `in_ready` stays 0; `Mout` unchanged.
- 3x3 load, then a second 1x1 load with value -7:
  - word 0 = -7;
  - words 1..8 re-zeroed.
- Assert `rst` after 4 of 9 elements of a 3x3 load:
  - next cycle `in_ready` = 0, `done` = 0, `Mout` = 0;
  - fresh 1x2 load of 9,8 completes correctly.
- `start` held high across DONE for 10 cycles:
  - `done` stays 1 throughout;
  - no restart until `start` drops.
